// File: rtl/fnd_sched_pkg.sv
// Mode encoding, page geometry and cyclic page arithmetic shared by the FND page scheduler.
// Latency: none (declarations only); backpressure: not applicable.
package fnd_sched_pkg;

   localparam int NUM_PAGES = 6;
   localparam int PAGE_W    = 3;

   typedef enum logic [1:0] {
      MODE_AUTO   = 2'd0,
      MODE_MANUAL = 2'd1,
      MODE_ALERT  = 2'd2
   } mode_t;

   // Page index 'step' positions after 'cur', wrapping 5 -> 0; step ranges 1..NUM_PAGES.
   function automatic logic [PAGE_W-1:0] page_wrap(input logic [PAGE_W-1:0] cur, input int step);
      int sum;
      sum = int'(cur) + step;
      if (sum >= NUM_PAGES) sum = sum - NUM_PAGES;
      return PAGE_W'(sum);
   endfunction

endpackage

// File: rtl/fnd_next_page.sv
// Cyclic next-set-bit finder: first set bit of mask strictly after cur, wrapping; cur itself if it is the only one.
// Latency: combinational; backpressure: none.
module fnd_next_page
   import fnd_sched_pkg::*;
(
   input  logic [NUM_PAGES-1:0] mask,
   input  logic [PAGE_W-1:0]    cur,
   output logic [PAGE_W-1:0]    nxt
);

   // Scan farthest-first so the nearest set bit is the last one written.
   always_comb begin
      nxt = cur;
      for (int step = NUM_PAGES; step >= 1; step--) begin
         if (mask[page_wrap(cur, step)]) nxt = page_wrap(cur, step);
      end
   end

endmodule

// File: rtl/fnd_page_scheduler.sv
// Chooses which of six status registers feeds the FND digit path: AUTO round-robin, MANUAL hold, optional ALERT (CHANGE_ALERT_EN).
// Latency: sw to page 3 cycles, shown register to fnd_reg 1 cycle; no backpressure, fnd_reg refreshes every cycle.
module fnd_page_scheduler
   import fnd_sched_pkg::*;
#(
   parameter int DWELL_CYCLES = 100_000_000,
   parameter int ALERT_CYCLES = 200_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] sw,
   input  logic [7:0] slv_reg0,
   input  logic [7:0] slv_reg1,
   input  logic [7:0] slv_reg2,
   input  logic [7:0] slv_reg3,
   input  logic [7:0] slv_reg4,
   input  logic [7:0] slv_reg5,
   output logic [7:0] fnd_reg,
   output logic [2:0] page,
   output logic [1:0] mode,
   output logic       alert
);

   localparam int                DW         = $clog2(DWELL_CYCLES);
   localparam logic [DW-1:0]     DWELL_LAST = DW'(DWELL_CYCLES - 1);
   localparam logic [PAGE_W-1:0] LAST_PAGE  = PAGE_W'(NUM_PAGES - 1);

   logic [7:0]           regs [NUM_PAGES];
   logic [NUM_PAGES-1:0] sw_m, sw_s, mask;
   logic                 onehot;
   mode_t                state_q, state_d;
   logic [PAGE_W-1:0]    page_q, page_d;
   logic [PAGE_W-1:0]    adv_page, low_page, man_page, win_page;
   logic [DW-1:0]        dwell_q, dwell_d;
   logic                 win, hold_done, alert_entry;

   assign regs[0] = slv_reg0;
   assign regs[1] = slv_reg1;
   assign regs[2] = slv_reg2;
   assign regs[3] = slv_reg3;
   assign regs[4] = slv_reg4;
   assign regs[5] = slv_reg5;

   // An all-off switch bank means "rotate through everything".
   assign mask   = (sw_s != '0) ? sw_s : '1;
   assign onehot = (sw_s != '0) && ((sw_s & (sw_s - 1'b1)) == '0);

   // Starting the scan after the last page yields the lowest set bit.
   fnd_next_page u_adv (.mask(mask), .cur(page_q),    .nxt(adv_page));
   fnd_next_page u_low (.mask(mask), .cur(LAST_PAGE), .nxt(low_page));
   fnd_next_page u_man (.mask(sw_s), .cur(LAST_PAGE), .nxt(man_page));

`ifdef CHANGE_ALERT_EN
   localparam int            HW        = $clog2(ALERT_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(ALERT_CYCLES - 1);

   logic [7:0]           snap_q [NUM_PAGES];
   logic [NUM_PAGES-1:0] changed;
   logic [HW-1:0]        hold_q;
   logic                 prime_q;

   always_comb begin
      changed = '0;
      for (int i = 0; i < NUM_PAGES; i++) begin
         changed[i] = mask[i] && (regs[i] != snap_q[i]);
      end
   end

   fnd_next_page u_win (.mask(changed), .cur(LAST_PAGE), .nxt(win_page));

   assign win         = (state_q == MODE_AUTO) && !prime_q && !onehot && (changed != '0);
   assign hold_done   = (hold_q == HOLD_LAST);
   assign alert_entry = (state_q == MODE_ALERT) && (hold_q == '0);

   // Masked snapshots stay stale during ALERT so pending changes are serviced afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prime_q <= 1'b1;
         hold_q  <= '0;
         for (int i = 0; i < NUM_PAGES; i++) snap_q[i] <= '0;
      end else begin
         prime_q <= 1'b0;
         hold_q  <= (state_q == MODE_ALERT && !hold_done) ? hold_q + 1'b1 : '0;
         for (int i = 0; i < NUM_PAGES; i++) begin
            if (prime_q || state_q == MODE_MANUAL || onehot || !mask[i] ||
                (win && win_page == PAGE_W'(i)))
               snap_q[i] <= regs[i];
         end
      end
   end
`else
   assign win         = 1'b0;
   assign win_page    = '0;
   assign hold_done   = (ALERT_CYCLES > 1);
   assign alert_entry = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_m    <= '0;
         sw_s    <= '0;
         state_q <= MODE_AUTO;
         page_q  <= '0;
         dwell_q <= '0;
         fnd_reg <= '0;
      end else begin
         sw_m    <= sw;
         sw_s    <= sw_m;
         state_q <= state_d;
         page_q  <= page_d;
         dwell_q <= dwell_d;
         fnd_reg <= regs[page_q];
      end
   end

   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      dwell_d = dwell_q;
      if (onehot) begin
         state_d = MODE_MANUAL;
         page_d  = man_page;
         dwell_d = '0;
      end else begin
         case (state_q)
            MODE_MANUAL: begin
               state_d = MODE_AUTO;
               page_d  = low_page;
               dwell_d = '0;
            end
            MODE_ALERT: begin
               if (hold_done) begin
                  state_d = MODE_AUTO;
                  page_d  = adv_page;
                  dwell_d = '0;
               end
            end
            default: begin
               // An alert outranks both dwell expiry and mask-driven advance.
               if (win) begin
                  state_d = MODE_ALERT;
                  page_d  = win_page;
                  dwell_d = '0;
               end else if (!mask[page_q] || dwell_q == DWELL_LAST) begin
                  page_d  = adv_page;
                  dwell_d = '0;
               end else begin
                  dwell_d = dwell_q + 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      mode  = state_q;
      alert = alert_entry;
   end

   assign page = page_q;

endmodule
